// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared definitions for the instruction prefetch queue.
//   FQ_DEPTH / FQ_PTR_W : default queue geometry (DEPTH must be a power of two)
//   FQ_NOP_INSTR        : word shown to decode while the queue is empty
//   fq_entry_t          : one queue entry, laid out {pc[95:64], pc_plus4[63:32], instr[31:0]}
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH     = 4;
    localparam int unsigned FQ_PTR_W     = 2;
    localparam int unsigned FQ_XLEN      = 32;
    localparam int unsigned FQ_ENTRY_W   = 3 * FQ_XLEN;
    localparam int unsigned FQ_INSTR_LSB = 0;
    localparam int unsigned FQ_PC4_LSB   = 32;
    localparam int unsigned FQ_PC_LSB    = 64;

    localparam logic [FQ_XLEN-1:0] FQ_NOP_INSTR = '0;

    // Packed struct: first member occupies the MSBs, matching the entry layout above.
    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] pc_plus4;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode side of the prefetch queue.
//   master : fetch + decode (drives push_*, flush, pop; sees stall_f and the head entry)
//   slave  : fetch_queue itself
//   push_valid/push_pc/push_pc_plus4/push_instr : word offered by fetch
//   stall_f : queue full
//   flush   : redirect, discard everything
//   pop     : decode consumes head
//   valid_d/pc_d/pc_plus4_d/instr_d : head entry
//   count   : occupied entries (0..DEPTH)
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned PTR_W = FQ_PTR_W
);

    logic               push_valid;
    logic [FQ_XLEN-1:0] push_pc;
    logic [FQ_XLEN-1:0] push_pc_plus4;
    logic [FQ_XLEN-1:0] push_instr;
    logic               stall_f;
    logic               flush;
    logic               pop;
    logic               valid_d;
    logic [FQ_XLEN-1:0] pc_d;
    logic [FQ_XLEN-1:0] pc_plus4_d;
    logic [FQ_XLEN-1:0] instr_d;
    logic [PTR_W:0]     count;

    modport master (
        output push_valid, push_pc, push_pc_plus4, push_instr, flush, pop,
        input  stall_f, valid_d, pc_d, pc_plus4_d, instr_d, count
    );

    modport slave (
        input  push_valid, push_pc, push_pc_plus4, push_instr, flush, pop,
        output stall_f, valid_d, pc_d, pc_plus4_d, instr_d, count
    );

endinterface

// File: rtl/fetch_queue_storage.sv
// fq_storage: DEPTH x 96-bit register file for the prefetch queue.
//   clk   : write clock
//   we    : write enable (accepted push only)
//   waddr : write pointer
//   wdata : entry to store
//   raddr : read pointer (asynchronous read)
//   rdata : entry at raddr
// Contents are intentionally not reset; the top masks outputs while empty.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH,
    parameter int unsigned PTR_W = FQ_PTR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output fq_entry_t        rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between fetch and decode with
// first-word fall-through to decode and a registered full flag to fetch.
//   clk   : rising-edge clock
//   reset : asynchronous reset, active-low
//   bus   : fetch_queue_if slave (push side, pop/flush, head entry, count)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned        DEPTH     = FQ_DEPTH,
    parameter int unsigned        PTR_W     = FQ_PTR_W,
    parameter logic [FQ_XLEN-1:0] NOP_INSTR = FQ_NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_next;
    logic             full;
    logic             not_empty;
    logic             do_push;
    logic             do_pop;
    fq_entry_t        wr_entry;
    fq_entry_t        rd_entry;

    // Full/empty come only from registered count, so stall_f has no path from pop.
    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);

    assign do_push = bus.push_valid & ~full & ~bus.flush;
    assign do_pop  = bus.pop & not_empty & ~bus.flush;

    always_comb begin
        count_next = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_next;
        end
    end

    assign wr_entry = '{pc: bus.push_pc, pc_plus4: bus.push_pc_plus4, instr: bus.push_instr};

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Storage is unreset, so the head is masked whenever the queue is empty.
    assign bus.valid_d    = not_empty;
    assign bus.stall_f    = full;
    assign bus.count      = count_q;
    assign bus.pc_d       = not_empty ? rd_entry.pc       : '0;
    assign bus.pc_plus4_d = not_empty ? rd_entry.pc_plus4 : '0;
    assign bus.instr_d    = not_empty ? rd_entry.instr    : NOP_INSTR;

endmodule
